fp_reg_dump: RTL and testbench

Read-side sequencer for the 32-entry floating-point register file. On a `start` pulse it walks the register file's asynchronous read port over an inclusive register range. Each captured word is presented, tagged with its register index, on a valid/ready output stream. The block sits beside the FP register file in the datapath and serves as the hardware replacement for software register-dump debug, feeding a trace or UART serializer downstream.

---
 rtl/fp_pkg.sv | 16 +
 rtl/fp_reg_dump.sv | 95 +++++++++
 tb/tb_fp_reg_dump.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared FP register-file constants and the dump sequencer state encoding.
// Used by the register file and the fp_reg_dump read-side sequencer.
package fp_pkg;

  localparam int FP_NUM_REGS = 32;
  localparam int FP_ADDR_W   = 5;
  localparam int FP_DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } fp_dump_state_t;

endpackage

// File: rtl/fp_reg_dump.sv
// Walks the FP register file over an inclusive (wrapping) range and streams index-tagged words.
// First word 2 cycles after start, then one word per 2 cycles; out_ready low stalls the single output register in place.
module fp_reg_dump
  import fp_pkg::*;
#(
  parameter int NUM_REGS = FP_NUM_REGS,
  parameter int ADDR_W   = FP_ADDR_W,
  parameter int DATA_W   = FP_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_reg,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_reg,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  fp_dump_state_t    state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] ptr_next;
  logic [ADDR_W-1:0] out_reg_q;
  logic [DATA_W-1:0] out_data_q;
  logic              at_last;

  // Explicit wrap keeps the sweep correct even if NUM_REGS is not a power of two.
  assign ptr_next = (ptr == ADDR_W'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;
  assign at_last  = (ptr == last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      last_q     <= '0;
      out_reg_q  <= '0;
      out_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr    <= first_reg;
            last_q <= last_reg;
            state  <= FETCH;
          end
        end
        FETCH: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            out_data_q <= rd_data;
            out_reg_q  <= ptr;
            state      <= SEND;
          end
        end
        SEND: begin
          if (abort) begin
            state <= IDLE;
          end else if (out_ready) begin
            if (at_last) begin
              state <= DONE;
            end else begin
              ptr   <= ptr_next;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // All outputs decode from registered state, so rd_data never reaches an output combinationally.
  assign rd_reg    = ptr;
  assign out_valid = (state == SEND);
  assign out_reg   = out_reg_q;
  assign out_data  = out_data_q;
  assign out_last  = out_valid && at_last;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_fp_reg_dump.sv
// Directed self-checking bench for fp_reg_dump with a behavioural asynchronous-read register file.
module tb_fp_reg_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic        abort;
  logic [4:0]  rd_reg;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_reg;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] rf [0:31];

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0]  q_reg  [$];
  logic [31:0] q_data [$];
  logic        q_last [$];
  int          q_cyc  [$];
  int          done_cyc;
  int          done_cnt;
  int          busy_cnt;
  int          hold_viol;
  logic        busy_after;

  always #5 clk = ~clk;

  assign rd_data = rf[rd_reg];

  fp_reg_dump dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .abort     (abort),
    .rd_reg    (rd_reg),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_reg   (out_reg),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // Drives one dump and records every handshake; cycle 0 is the cycle start is presented.
  // rmode 0: out_ready always 1; rmode 1: 5-cycle stalls then 4 ready cycles.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int rmode,
                          input int restart_cyc, input int max_cyc);
    logic        prev_stall;
    logic [4:0]  prev_reg;
    logic [31:0] prev_data;
    q_reg.delete(); q_data.delete(); q_last.delete(); q_cyc.delete();
    done_cyc = -1; done_cnt = 0; busy_cnt = 0; hold_viol = 0; busy_after = 1'b1;
    prev_stall = 1'b0; prev_reg = '0; prev_data = '0;
    @(posedge clk); #1;
    start = 1'b1; first_reg = f; last_reg = l; out_ready = 1'b1;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(posedge clk); #1;
      start     = (cyc == restart_cyc);
      first_reg = 5'd9;
      last_reg  = 5'd9;
      out_ready = (rmode == 0) ? 1'b1 : ((cyc % 9) >= 5);
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = busy;
        break;
      end
      if (busy) busy_cnt++;
      if (prev_stall && (!out_valid || out_reg !== prev_reg || out_data !== prev_data))
        hold_viol++;
      if (out_valid && out_ready) begin
        q_reg.push_back(out_reg);
        q_data.push_back(out_data);
        q_last.push_back(out_last);
        q_cyc.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_reg   = out_reg;
      prev_data  = out_data;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
    start = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (rd_reg !== 5'd0) begin n_err++; $display("FAIL reset_rd_reg got %0d want 0", rd_reg); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_cmp++; if (out_reg !== 5'd0 || out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_reg_last got %0d/%b want 0/0", out_reg, out_last); end
  endtask

  task automatic test_full_dump();
    run_dump(5'd0, 5'd31, 0, 0, 200);
    n_cmp++; if (q_reg.size() !== 32) begin n_err++; $display("FAIL full_count got %0d want 32", q_reg.size()); end
    for (int k = 0; k < q_reg.size(); k++) begin
      n_cmp++; if (q_reg[k] !== 5'(k)) begin n_err++; $display("FAIL full_reg[%0d] got %0d want %0d", k, q_reg[k], k); end
      n_cmp++; if (q_data[k] !== 32'h3F80_0000 + 32'(k)) begin n_err++; $display("FAIL full_data[%0d] got %h want %h", k, q_data[k], 32'h3F80_0000 + 32'(k)); end
      n_cmp++; if (q_last[k] !== (k == 31)) begin n_err++; $display("FAIL full_last[%0d] got %b want %b", k, q_last[k], (k == 31)); end
      n_cmp++; if (q_cyc[k] !== 2 + 2 * k) begin n_err++; $display("FAIL full_cycle[%0d] got %0d want %0d", k, q_cyc[k], 2 + 2 * k); end
    end
    n_cmp++; if (done_cyc !== 65) begin n_err++; $display("FAIL full_done_cycle got %0d want 65", done_cyc); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL full_done_count got %0d want 1", done_cnt); end
    n_cmp++; if (busy_cnt !== 65) begin n_err++; $display("FAIL full_busy_cycles got %0d want 65", busy_cnt); end
    n_cmp++; if (busy_after !== 1'b0) begin n_err++; $display("FAIL full_busy_after got %b want 0", busy_after); end
  endtask

  task automatic test_wrap();
    logic [4:0] exp_reg;
    run_dump(5'd30, 5'd1, 0, 0, 100);
    n_cmp++; if (q_reg.size() !== 4) begin n_err++; $display("FAIL wrap_count got %0d want 4", q_reg.size()); end
    for (int k = 0; k < q_reg.size(); k++) begin
      exp_reg = 5'(30 + k);
      n_cmp++; if (q_reg[k] !== exp_reg) begin n_err++; $display("FAIL wrap_reg[%0d] got %0d want %0d", k, q_reg[k], exp_reg); end
      n_cmp++; if (q_data[k] !== 32'h3F80_0000 + 32'(exp_reg)) begin n_err++; $display("FAIL wrap_data[%0d] got %h want %h", k, q_data[k], 32'h3F80_0000 + 32'(exp_reg)); end
      n_cmp++; if (q_last[k] !== (k == 3)) begin n_err++; $display("FAIL wrap_last[%0d] got %b want %b", k, q_last[k], (k == 3)); end
    end
    n_cmp++; if (done_cyc !== 9) begin n_err++; $display("FAIL wrap_done_cycle got %0d want 9", done_cyc); end
  endtask

  task automatic test_backpressure();
    run_dump(5'd2, 5'd12, 1, 0, 400);
    n_cmp++; if (q_reg.size() !== 11) begin n_err++; $display("FAIL stall_count got %0d want 11", q_reg.size()); end
    for (int k = 0; k < q_reg.size(); k++) begin
      n_cmp++; if (q_reg[k] !== 5'(2 + k)) begin n_err++; $display("FAIL stall_reg[%0d] got %0d want %0d", k, q_reg[k], 2 + k); end
      n_cmp++; if (q_data[k] !== 32'h3F80_0000 + 32'(2 + k)) begin n_err++; $display("FAIL stall_data[%0d] got %h want %h", k, q_data[k], 32'h3F80_0000 + 32'(2 + k)); end
      n_cmp++; if (q_last[k] !== (k == 10)) begin n_err++; $display("FAIL stall_last[%0d] got %b want %b", k, q_last[k], (k == 10)); end
    end
    n_cmp++; if (hold_viol !== 0) begin n_err++; $display("FAIL stall_hold_violations got %0d want 0", hold_viol); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL stall_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_single();
    rf[7] = 32'hC049_0FDB;
    run_dump(5'd7, 5'd7, 0, 0, 50);
    n_cmp++; if (q_reg.size() !== 1) begin n_err++; $display("FAIL single_count got %0d want 1", q_reg.size()); end
    if (q_reg.size() > 0) begin
      n_cmp++; if (q_reg[0] !== 5'd7) begin n_err++; $display("FAIL single_reg got %0d want 7", q_reg[0]); end
      n_cmp++; if (q_data[0] !== 32'hC049_0FDB) begin n_err++; $display("FAIL single_data got %h want c0490fdb", q_data[0]); end
      n_cmp++; if (q_last[0] !== 1'b1) begin n_err++; $display("FAIL single_last got %b want 1", q_last[0]); end
    end
    n_cmp++; if (done_cyc !== 3) begin n_err++; $display("FAIL single_done_cycle got %0d want 3", done_cyc); end
  endtask

  task automatic test_start_while_busy();
    run_dump(5'd4, 5'd8, 0, 5, 100);
    n_cmp++; if (q_reg.size() !== 5) begin n_err++; $display("FAIL restart_count got %0d want 5", q_reg.size()); end
    for (int k = 0; k < q_reg.size(); k++) begin
      n_cmp++; if (q_reg[k] !== 5'(4 + k)) begin n_err++; $display("FAIL restart_reg[%0d] got %0d want %0d", k, q_reg[k], 4 + k); end
    end
    n_cmp++; if (done_cyc !== 11) begin n_err++; $display("FAIL restart_done_cycle got %0d want 11", done_cyc); end
  endtask

  task automatic test_abort();
    logic found;
    int   dpulses;
    found = 1'b0; dpulses = 0;
    @(posedge clk); #1;
    start = 1'b1; first_reg = 5'd3; last_reg = 5'd10; out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (out_valid && out_reg == 5'd5) begin
        out_ready = 1'b0;
        found = 1'b1;
        break;
      end
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL abort_reach_reg5 got %b want 1", found); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_reg !== 5'd5 || out_data !== 32'h3F80_0005) begin n_err++; $display("FAIL abort_stall_hold got %b/%0d/%h want 1/5/3f800005", out_valid, out_reg, out_data); end
    abort = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
    for (int c = 0; c < 5; c++) begin
      if (done) dpulses++;
      @(posedge clk); #1;
    end
    n_cmp++; if (dpulses !== 0) begin n_err++; $display("FAIL abort_done_pulses got %0d want 0", dpulses); end
    run_dump(5'd20, 5'd22, 0, 0, 50);
    n_cmp++; if (q_reg.size() !== 3) begin n_err++; $display("FAIL abort_restart_count got %0d want 3", q_reg.size()); end
    if (q_reg.size() > 0) begin
      n_cmp++; if (q_reg[0] !== 5'd20) begin n_err++; $display("FAIL abort_restart_first got %0d want 20", q_reg[0]); end
    end
    n_cmp++; if (done_cyc !== 7) begin n_err++; $display("FAIL abort_restart_done_cycle got %0d want 7", done_cyc); end
  endtask

  task automatic test_async_reset();
    logic found;
    found = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; first_reg = 5'd0; last_reg = 5'd31; out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (out_valid && out_reg == 5'd3) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL areset_reach_reg3 got %b want 1", found); end
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_idle_after got %b want 0", busy); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    first_reg = '0; last_reg = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h3F80_0000 + 32'(i);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_full_dump();
    test_wrap();
    test_backpressure();
    test_single();
    test_start_while_busy();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
